// File: rtl/bf_pkg.sv
// Shared definitions for the BF interpreter bus: request opcodes, the bus
// controller state encoding, read-source selector and memory region bits.
package bf_pkg;

  typedef enum logic [2:0] {
    BusNone      = 3'd0,
    BusReadProg  = 3'd1,
    BusReadData  = 3'd2,
    BusWriteData = 3'd3,
    BusReadIo    = 3'd4,
    BusWriteIo   = 3'd5
  } bus_op_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_IN_WAIT  = 2'd1,
    ST_OUT_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } bus_state_t;

  typedef enum logic {
    SRC_MEM = 1'b0,
    SRC_IO  = 1'b1
  } rd_src_t;

  localparam logic REGION_PROG = 1'b0;
  localparam logic REGION_DATA = 1'b1;

  // Region bit for a memory request: only program fetches use the low half.
  function automatic logic region_of(input bus_op_t op);
    return (op == BusReadProg) ? REGION_PROG : REGION_DATA;
  endfunction

endpackage

// File: rtl/bf_byte_slot.sv
// One-entry output byte register. A push always wins and may coincide with
// a pop of the previous byte; the full flag doubles as the stream valid.
module bf_byte_slot #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [BUS_WIDTH-1:0] din,
  output logic                 full,
  output logic [BUS_WIDTH-1:0] dout
);

  // Slot occupancy and contents; data only changes on a push so it stays
  // stable while the consumer back-pressures.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      dout <= '0;
    end else if (push) begin
      full <= 1'b1;
      dout <= din;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/bf_bus_ctrl.sv
// Bus controller between the BF core and its SRAM / byte streams.
// Optional feature macro: BF_BUS_EOF_EN adds the in_eof port so that a
// ReadIo on an exhausted input completes with EOF_VALUE instead of stalling.
module bf_bus_ctrl
  import bf_pkg::*;
#(
  parameter int                   ADDR_WIDTH = 15,
  parameter int                   BUS_WIDTH  = 8,
  parameter logic [BUS_WIDTH-1:0] EOF_VALUE  = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  input  bus_op_t               bus_op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [BUS_WIDTH-1:0]  val_out,
  output logic [BUS_WIDTH-1:0]  val_in,
  output logic                  core_enable,
  input  logic                  core_halted,
  output logic [ADDR_WIDTH:0]   mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [BUS_WIDTH-1:0]  mem_wdata,
  input  logic [BUS_WIDTH-1:0]  mem_rdata,
  input  logic                  in_valid,
  input  logic [BUS_WIDTH-1:0]  in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [BUS_WIDTH-1:0]  out_data,
  input  logic                  out_ready,
`ifdef BF_BUS_EOF_EN
  input  logic                  in_eof,
`endif
  output logic                  done
);

  bus_state_t           state, state_n;
  rd_src_t              rd_src;
  logic [BUS_WIDTH-1:0] io_rd;
  logic                 grant, active, eof_ok;
  logic                 rd_mem, rd_io, push, pop, slot_full;

`ifdef BF_BUS_EOF_EN
  assign eof_ok = in_eof;
`else
  assign eof_ok = 1'b0;
`endif

  // Requests are only served while running, out of reset and not finished.
  assign active = run & ~reset & (state != ST_DONE);
  assign pop    = slot_full & out_ready;

  bf_byte_slot #(.BUS_WIDTH(BUS_WIDTH)) u_slot (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (val_out),
    .full  (slot_full),
    .dout  (out_data)
  );

  // State register, read-source latch and captured input byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_RUN;
      rd_src <= SRC_MEM;
      io_rd  <= '0;
    end else begin
      state <= state_n;
      if (rd_mem) rd_src <= SRC_MEM;
      if (rd_io) begin
        rd_src <= SRC_IO;
        io_rd  <= in_valid ? in_data : EOF_VALUE;
      end
    end
  end

  // Grant decision, strobes and next state for the current request.
  always_comb begin
    state_n   = state;
    grant     = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    in_ready  = 1'b0;
    push      = 1'b0;
    rd_mem    = 1'b0;
    rd_io     = 1'b0;
    if (active) begin
      case (bus_op)
        BusReadProg, BusReadData: begin
          grant    = 1'b1;
          mem_re   = 1'b1;
          mem_addr = {region_of(bus_op), addr};
          rd_mem   = 1'b1;
        end
        BusWriteData: begin
          grant     = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {REGION_DATA, addr};
          mem_wdata = val_out;
        end
        BusReadIo: begin
          if (in_valid | eof_ok) begin
            grant    = 1'b1;
            rd_io    = 1'b1;
            in_ready = in_valid;
          end
        end
        BusWriteIo: begin
          if (~slot_full | out_ready) begin
            grant = 1'b1;
            push  = 1'b1;
          end
        end
        default: grant = 1'b1;
      endcase
      if (grant)                    state_n = ST_RUN;
      else if (bus_op == BusReadIo) state_n = ST_IN_WAIT;
      else                          state_n = ST_OUT_WAIT;
      if ((state == ST_RUN) && core_halted) state_n = ST_DONE;
    end
  end

  assign core_enable = grant;
  assign out_valid   = slot_full;
  assign done        = (state == ST_DONE) & ~slot_full;
  assign val_in      = reset ? '0 : ((rd_src == SRC_IO) ? io_rd : mem_rdata);

endmodule

// File: tb/tb_bf_bus_ctrl.sv
// Bench for bf_bus_ctrl: directed scenarios plus a randomized run checked
// against a queue/array reference model. Build with BF_BUS_EOF_EN to cover
// the end-of-file path as well.
module tb_bf_bus_ctrl;
  import bf_pkg::*;

  logic          clock, reset, run;
  bus_op_t       bus_op;
  logic [14:0]   addr;
  logic [7:0]    val_out, val_in;
  logic          core_enable, core_halted;
  logic [15:0]   mem_addr;
  logic          mem_re, mem_we;
  logic [7:0]    mem_wdata, mem_rdata;
  logic          in_valid, in_ready;
  logic [7:0]    in_data;
  logic          out_valid, out_ready;
  logic [7:0]    out_data;
  logic          in_eof;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sram    [0:65535];
  logic [7:0] ref_mem [0:65535];

  bf_bus_ctrl #(.ADDR_WIDTH(15), .BUS_WIDTH(8), .EOF_VALUE(8'h00)) dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .bus_op      (bus_op),
    .addr        (addr),
    .val_out     (val_out),
    .val_in      (val_in),
    .core_enable (core_enable),
    .core_halted (core_halted),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
`ifdef BF_BUS_EOF_EN
    .in_eof      (in_eof),
`endif
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous SRAM: read data appears the cycle after mem_re and holds.
  initial begin
    for (int i = 0; i < 65536; i++) sram[i] = 8'(i * 7 + 3);
    mem_rdata = 8'h00;
  end
  always @(posedge clock) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= sram[mem_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    run = 1'b1; bus_op = BusNone; addr = '0; val_out = '0;
    core_halted = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; in_eof = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1'b1; bus_op = BusWriteData; addr = 15'd5; val_out = 8'h77;
    @(negedge clock); #1;
    n_checks++; if (core_enable !== 1'b0) begin n_fail++; $display("FAIL rst_core_enable got %b want 0", core_enable); end
    n_checks++; if (mem_we !== 1'b0)      begin n_fail++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    n_checks++; if (mem_re !== 1'b0)      begin n_fail++; $display("FAIL rst_mem_re got %b want 0", mem_re); end
    n_checks++; if (mem_addr !== 16'h0)   begin n_fail++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    n_checks++; if (mem_wdata !== 8'h0)   begin n_fail++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
    n_checks++; if (in_ready !== 1'b0)    begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 8'h0)    begin n_fail++; $display("FAIL rst_out_data got %h want 0", out_data); end
    n_checks++; if (done !== 1'b0)        begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
    n_checks++; if (val_in !== 8'h0)      begin n_fail++; $display("FAIL rst_val_in got %h want 0", val_in); end
    @(negedge clock);
    reset = 1'b0; bus_op = BusNone;
  endtask

  task automatic test_mem_rw();
    @(negedge clock);
    bus_op = BusWriteData; addr = 15'd5; val_out = 8'h2B; #1;
    n_checks++; if (mem_we !== 1'b1)        begin n_fail++; $display("FAIL wr_mem_we got %b want 1", mem_we); end
    n_checks++; if (mem_addr !== 16'h8005)  begin n_fail++; $display("FAIL wr_mem_addr got %h want 8005", mem_addr); end
    n_checks++; if (mem_wdata !== 8'h2B)    begin n_fail++; $display("FAIL wr_mem_wdata got %h want 2b", mem_wdata); end
    n_checks++; if (core_enable !== 1'b1)   begin n_fail++; $display("FAIL wr_core_enable got %b want 1", core_enable); end
    @(negedge clock);
    bus_op = BusReadData; addr = 15'd5; val_out = 8'h00; #1;
    n_checks++; if (mem_re !== 1'b1)        begin n_fail++; $display("FAIL rd_mem_re got %b want 1", mem_re); end
    n_checks++; if (mem_addr !== 16'h8005)  begin n_fail++; $display("FAIL rd_mem_addr got %h want 8005", mem_addr); end
    @(negedge clock);
    bus_op = BusNone; #1;
    n_checks++; if (val_in !== 8'h2B)       begin n_fail++; $display("FAIL rd_val_in got %h want 2b", val_in); end
  endtask

  task automatic test_read_prog();
    @(negedge clock);
    sram[0] = 8'h2B;
    bus_op = BusReadProg; addr = 15'd0; #1;
    n_checks++; if (mem_addr !== 16'h0000)  begin n_fail++; $display("FAIL prog_mem_addr got %h want 0000", mem_addr); end
    n_checks++; if (mem_re !== 1'b1)        begin n_fail++; $display("FAIL prog_mem_re got %b want 1", mem_re); end
    n_checks++; if (core_enable !== 1'b1)   begin n_fail++; $display("FAIL prog_en0 got %b want 1", core_enable); end
    @(negedge clock);
    bus_op = BusNone; #1;
    n_checks++; if (val_in !== 8'h2B)       begin n_fail++; $display("FAIL prog_val_in got %h want 2b", val_in); end
    n_checks++; if (core_enable !== 1'b1)   begin n_fail++; $display("FAIL prog_en1 got %b want 1", core_enable); end
  endtask

  task automatic test_io_read_stall();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      bus_op = BusReadIo; in_valid = 1'b0; in_data = 8'h99; #1;
      n_checks++; if (core_enable !== 1'b0) begin n_fail++; $display("FAIL ior_stall_en[%0d] got %b want 0", i, core_enable); end
      n_checks++; if (in_ready !== 1'b0)    begin n_fail++; $display("FAIL ior_stall_rdy[%0d] got %b want 0", i, in_ready); end
    end
    @(negedge clock);
    in_valid = 1'b1; in_data = 8'h41; #1;
    n_checks++; if (in_ready !== 1'b1)      begin n_fail++; $display("FAIL ior_grant_rdy got %b want 1", in_ready); end
    n_checks++; if (core_enable !== 1'b1)   begin n_fail++; $display("FAIL ior_grant_en got %b want 1", core_enable); end
    @(negedge clock);
    bus_op = BusNone; in_valid = 1'b0; in_data = 8'h00; #1;
    n_checks++; if (val_in !== 8'h41)       begin n_fail++; $display("FAIL ior_val_in got %h want 41", val_in); end
    n_checks++; if (in_ready !== 1'b0)      begin n_fail++; $display("FAIL ior_idle_rdy got %b want 0", in_ready); end
  endtask

`ifdef BF_BUS_EOF_EN
  task automatic test_eof();
    @(negedge clock);
    bus_op = BusReadIo; in_valid = 1'b0; in_eof = 1'b1; in_data = 8'h33; #1;
    n_checks++; if (core_enable !== 1'b1)   begin n_fail++; $display("FAIL eof_en got %b want 1", core_enable); end
    n_checks++; if (in_ready !== 1'b0)      begin n_fail++; $display("FAIL eof_rdy got %b want 0", in_ready); end
    @(negedge clock);
    in_valid = 1'b1; in_data = 8'h5A; #1;
    n_checks++; if (val_in !== 8'h00)       begin n_fail++; $display("FAIL eof_val_in got %h want 00", val_in); end
    n_checks++; if (in_ready !== 1'b1)      begin n_fail++; $display("FAIL eof_prio_rdy got %b want 1", in_ready); end
    @(negedge clock);
    bus_op = BusNone; in_valid = 1'b0; in_eof = 1'b0; #1;
    n_checks++; if (val_in !== 8'h5A)       begin n_fail++; $display("FAIL eof_prio_val got %h want 5a", val_in); end
  endtask
`endif

  task automatic test_back_to_back();
    @(negedge clock);
    out_ready = 1'b0; bus_op = BusWriteIo; val_out = 8'h48; #1;
    n_checks++; if (core_enable !== 1'b1)   begin n_fail++; $display("FAIL b2b_first_en got %b want 1", core_enable); end
    n_checks++; if (out_valid !== 1'b0)     begin n_fail++; $display("FAIL b2b_empty got %b want 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      bus_op = BusWriteIo; val_out = 8'h49; out_ready = 1'b0; #1;
      n_checks++; if (core_enable !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_en[%0d] got %b want 0", i, core_enable); end
      n_checks++; if (out_valid !== 1'b1)   begin n_fail++; $display("FAIL b2b_stall_ov[%0d] got %b want 1", i, out_valid); end
      n_checks++; if (out_data !== 8'h48)   begin n_fail++; $display("FAIL b2b_stall_od[%0d] got %h want 48", i, out_data); end
    end
    @(negedge clock);
    out_ready = 1'b1; #1;
    n_checks++; if (core_enable !== 1'b1)   begin n_fail++; $display("FAIL b2b_pushpop_en got %b want 1", core_enable); end
    n_checks++; if (out_data !== 8'h48)     begin n_fail++; $display("FAIL b2b_pop_data got %h want 48", out_data); end
    @(negedge clock);
    bus_op = BusNone; out_ready = 1'b0; #1;
    n_checks++; if (out_valid !== 1'b1)     begin n_fail++; $display("FAIL b2b_second_ov got %b want 1", out_valid); end
    n_checks++; if (out_data !== 8'h49)     begin n_fail++; $display("FAIL b2b_second_od got %h want 49", out_data); end
  endtask

  task automatic test_done_and_reset();
    @(negedge clock);
    core_halted = 1'b1; bus_op = BusNone; out_ready = 1'b0; #1;
    n_checks++; if (done !== 1'b0)          begin n_fail++; $display("FAIL done_pre got %b want 0", done); end
    @(negedge clock); #1;
    n_checks++; if (done !== 1'b0)          begin n_fail++; $display("FAIL done_full got %b want 0", done); end
    n_checks++; if (core_enable !== 1'b0)   begin n_fail++; $display("FAIL done_state_en got %b want 0", core_enable); end
    @(negedge clock);
    out_ready = 1'b1; #1;
    n_checks++; if (done !== 1'b0)          begin n_fail++; $display("FAIL done_popcyc got %b want 0", done); end
    @(negedge clock);
    out_ready = 1'b0; #1;
    n_checks++; if (done !== 1'b1)          begin n_fail++; $display("FAIL done_after_pop got %b want 1", done); end
    n_checks++; if (out_valid !== 1'b0)     begin n_fail++; $display("FAIL done_ov got %b want 0", out_valid); end
    @(negedge clock);
    core_halted = 1'b0; bus_op = BusReadData; #1;
    n_checks++; if (done !== 1'b1)          begin n_fail++; $display("FAIL done_sticky got %b want 1", done); end
    n_checks++; if (core_enable !== 1'b0)   begin n_fail++; $display("FAIL done_no_grant got %b want 0", core_enable); end
    reset = 1'b1; #1;
    n_checks++; if (done !== 1'b0)          begin n_fail++; $display("FAIL done_reset got %b want 0", done); end
    @(negedge clock);
    reset = 1'b0; bus_op = BusWriteIo; val_out = 8'hAA; out_ready = 1'b0; #1;
    n_checks++; if (core_enable !== 1'b1)   begin n_fail++; $display("FAIL rs_first_wr got %b want 1", core_enable); end
    @(negedge clock);
    val_out = 8'hBB; #1;
    n_checks++; if (core_enable !== 1'b0)   begin n_fail++; $display("FAIL rs_stall got %b want 0", core_enable); end
    #2; reset = 1'b1; #1;
    n_checks++; if (out_valid !== 1'b0)     begin n_fail++; $display("FAIL rs_ov_cleared got %b want 0", out_valid); end
    @(negedge clock);
    reset = 1'b0; #1;
    n_checks++; if (core_enable !== 1'b1)   begin n_fail++; $display("FAIL rs_back_to_run got %b want 1", core_enable); end
    @(negedge clock);
    bus_op = BusNone; #1;
    n_checks++; if (out_data !== 8'hBB)     begin n_fail++; $display("FAIL rs_new_byte got %h want bb", out_data); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] exp_val_in;
    bit         vin_known;
    logic [2:0] opc;
    int         k;
    bit         exp_g, exp_re, exp_we, exp_rdy;
    logic [15:0] exp_addr;
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = sram[i];
    vin_known = 1'b0; exp_val_in = '0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clock);
      opc       = 3'($urandom_range(0, 7));
      k         = int'(opc);
      bus_op    = bus_op_t'(opc);
      addr      = 15'($urandom_range(0, 15));
      val_out   = 8'($urandom);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      run       = ($urandom_range(0, 7) != 0);
      #1;
      if (vin_known) begin
        n_checks++; if (val_in !== exp_val_in) begin n_fail++; $display("FAIL rnd_val_in c=%0d got %h want %h", c, val_in, exp_val_in); end
      end
      n_checks++; if (out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_out_valid c=%0d got %b want %b", c, out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        n_checks++; if (out_data !== q[0]) begin n_fail++; $display("FAIL rnd_out_data c=%0d got %h want %h", c, out_data, q[0]); end
      end
      exp_re   = run && (k == 1 || k == 2);
      exp_we   = run && (k == 3);
      exp_rdy  = run && (k == 4) && in_valid;
      exp_g    = run && ((k == 4) ? in_valid :
                         (k == 5) ? (q.size() == 0 || out_ready) : 1'b1);
      exp_addr = {(k != 1), addr};
      n_checks++; if (core_enable !== exp_g) begin n_fail++; $display("FAIL rnd_core_enable c=%0d op=%0d got %b want %b", c, k, core_enable, exp_g); end
      n_checks++; if (mem_re !== exp_re)     begin n_fail++; $display("FAIL rnd_mem_re c=%0d got %b want %b", c, mem_re, exp_re); end
      n_checks++; if (mem_we !== exp_we)     begin n_fail++; $display("FAIL rnd_mem_we c=%0d got %b want %b", c, mem_we, exp_we); end
      n_checks++; if (in_ready !== exp_rdy)  begin n_fail++; $display("FAIL rnd_in_ready c=%0d got %b want %b", c, in_ready, exp_rdy); end
      n_checks++; if (done !== 1'b0)         begin n_fail++; $display("FAIL rnd_done c=%0d got %b want 0", c, done); end
      if (exp_re || exp_we) begin
        n_checks++; if (mem_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_mem_addr c=%0d got %h want %h", c, mem_addr, exp_addr); end
      end
      if (exp_we) begin
        n_checks++; if (mem_wdata !== val_out) begin n_fail++; $display("FAIL rnd_mem_wdata c=%0d got %h want %h", c, mem_wdata, val_out); end
      end
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (k == 5 && exp_g) q.push_back(val_out);
      if (exp_re) begin exp_val_in = ref_mem[exp_addr]; vin_known = 1'b1; end
      if (k == 4 && exp_g) begin exp_val_in = in_data; vin_known = 1'b1; end
      if (exp_we) ref_mem[exp_addr] = val_out;
    end
    @(negedge clock);
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_mem_rw();
    test_read_prog();
    test_io_read_stall();
`ifdef BF_BUS_EOF_EN
    test_eof();
`endif
    test_back_to_back();
    test_done_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
